arbitro_sumador: RTL and testbench

Shares a single registered 32-bit adder among several requesters in the processor datapath, such as the PC incrementer, the branch-target calculator and the load/store address generator. Each cycle a round-robin arbiter picks one valid request and adds its operands. The sum, carry, signed overflow and the winning requester's index are captured in an output register with a valid/ready handshake. Throughput is one addition per cycle when the consumer never stalls.

---
 rtl/arbitro_sumador_if.sv | 31 +++
 rtl/arbitro_sumador.sv | 116 +++++++++++
 tb/tb_arbitro_sumador.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_sumador_if.sv
// Bundle of the requester-side and consumer-side handshakes of the shared adder.
// The master modport is the environment (requesters + result consumer); the
// slave modport is the adder block itself.
interface arbitro_sumador_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_ready;

    logic                   res_valid;
    logic                   res_ready;
    logic [WIDTH-1:0]       res_sum;
    logic                   res_carry;
    logic                   res_ovf;
    logic [ID_W-1:0]        res_id;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_sum, res_carry, res_ovf, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_sum, res_carry, res_ovf, res_id
    );
endinterface

// File: rtl/arbitro_sumador.sv
// Single registered adder shared by N_REQ requesters through a round-robin
// arbiter. One accept per cycle while the consumer keeps res_ready high; the
// result register doubles as the output pipeline stage.
module arbitro_sumador #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
) (
    input logic              clk,
    input logic              reset_n,
    arbitro_sumador_if.slave bus
);
    localparam int ID_W = $clog2(N_REQ);

    // Result register and round-robin pointer.
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_sum_q,   res_sum_d;
    logic             res_carry_q, res_carry_d;
    logic             res_ovf_q,   res_ovf_d;
    logic [ID_W-1:0]  res_id_q,    res_id_d;
    logic [ID_W-1:0]  prio_q,      prio_d;

    logic             can_accept;
    logic             found;
    logic             accept;
    logic [ID_W-1:0]  win;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   full_sum;

    // The output slot is free when empty or being drained this cycle.
    assign can_accept = !res_valid_q || bus.res_ready;
    assign accept     = can_accept && found;

    // Round-robin search: first valid requester starting at prio_q, wrapping.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] cand;
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        found = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx  = (int'(prio_q) + k) % N_REQ;
            cand = ID_W'(idx);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Operand mux and one-hot grant; grants are suppressed while in reset.
    always_comb begin
        op_a          = '0;
        op_b          = '0;
        bus.req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == ID_W'(i)) begin
                op_a = bus.req_a[i*WIDTH +: WIDTH];
                op_b = bus.req_b[i*WIDTH +: WIDTH];
                bus.req_ready[i] = accept && reset_n;
            end
        end
    end

    // Widened add gives the unsigned carry in the top bit.
    assign full_sum = {1'b0, op_a} + {1'b0, op_b};

    // Next state: capture on accept, clear valid on a pure drain, else hold.
    always_comb begin
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_carry_d = res_carry_q;
        res_ovf_d   = res_ovf_q;
        res_id_d    = res_id_q;
        prio_d      = prio_q;
        if (accept) begin
            res_valid_d = 1'b1;
            res_sum_d   = full_sum[WIDTH-1:0];
            res_carry_d = full_sum[WIDTH];
            res_ovf_d   = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                          (full_sum[WIDTH-1] != op_a[WIDTH-1]);
            res_id_d    = win;
            prio_d      = (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
        end else if (res_valid_q && bus.res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any pending result and the pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_carry_q <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_id_q    <= '0;
            prio_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_carry_q <= res_carry_d;
            res_ovf_q   <= res_ovf_d;
            res_id_q    <= res_id_d;
            prio_q      <= prio_d;
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_sum   = res_sum_q;
    assign bus.res_carry = res_carry_q;
    assign bus.res_ovf   = res_ovf_q;
    assign bus.res_id    = res_id_q;
endmodule

// File: tb/tb_arbitro_sumador.sv
// Bench for arbitro_sumador: directed scenarios followed by a randomized run,
// all compared against a behavioural model of the arbiter and adder.
module tb_arbitro_sumador;
    localparam int N = 4;
    localparam int W = 32;

    logic clk;
    logic reset_n;
    int   tests = 0;
    int   fails = 0;

    arbitro_sumador_if #(.N_REQ(N), .WIDTH(W)) bus ();

    arbitro_sumador #(.N_REQ(N), .WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Behavioural model state.
    int          m_prio;
    bit          m_valid;
    logic [31:0] m_sum;
    bit          m_carry;
    bit          m_ovf;
    int          m_id;
    int          last_w;

    logic [31:0] op_a [N];
    logic [31:0] op_b [N];
    bit          pend [N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prio  = 0;
        m_valid = 0;
        m_sum   = '0;
        m_carry = 0;
        m_ovf   = 0;
        m_id    = 0;
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
    endtask

    // One clock: check outputs and grant against the model, then advance it.
    // want >= 0 : directed grant expectation, -1 : no grant, -2 : don't care.
    task automatic cycle(input int want = -2);
        int          w;
        bit          can;
        logic [63:0] exp_rdy;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] full;
        longint      s;
        #1;
        can = !m_valid || bus.res_ready;
        w   = -1;
        if (reset_n && can) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && bus.req_valid[(m_prio + k) % N]) w = (m_prio + k) % N;
            end
        end
        exp_rdy = (w >= 0) ? (64'd1 << w) : 64'd0;
        check("req_ready", bus.req_ready, exp_rdy);
        if (want != -2) check("grant_directed", bus.req_ready, (want >= 0) ? (64'd1 << want) : 64'd0);
        check("res_valid", bus.res_valid, m_valid);
        check("res_sum",   bus.res_sum,   m_sum);
        check("res_carry", bus.res_carry, m_carry);
        check("res_ovf",   bus.res_ovf,   m_ovf);
        check("res_id",    bus.res_id,    m_id);
        last_w = w;
        @(posedge clk);
        if (w >= 0) begin
            a       = bus.req_a[w*W +: W];
            b       = bus.req_b[w*W +: W];
            full    = 64'(a) + 64'(b);
            s       = longint'($signed(a)) + longint'($signed(b));
            m_sum   = full[31:0];
            m_carry = full[32];
            m_ovf   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            m_id    = w;
            m_valid = 1;
            m_prio  = (w + 1) % N;
        end else if (m_valid && bus.res_ready) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] corner_a [3];
        logic [31:0] corner_b [3];
        logic [31:0] corner_s [3];
        bit          corner_c [3];
        bit          corner_v [3];
        int          rr_seq   [5];
        logic [31:0] held_sum;
        logic [1:0]  held_id;

        corner_a = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        corner_b = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000};
        corner_s = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
        corner_c = '{1'b1, 1'b0, 1'b1};
        corner_v = '{1'b0, 1'b1, 1'b1};
        rr_seq   = '{0, 1, 2, 3, 0};

        // Reset: outputs zero and no grant even with every request raised.
        reset_n       = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b1;
        model_reset();
        @(negedge clk);
        bus.req_valid = 4'b1111;
        #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_sum",   bus.res_sum,   0);
        check("rst_res_id",    bus.res_id,    0);
        @(negedge clk);
        reset_n       = 1'b1;
        bus.req_valid = '0;

        // Single request 5 + 7 on requester 0.
        set_ops(0, 32'd5, 32'd7);
        bus.req_valid = 4'b0001;
        cycle(0);
        bus.req_valid = '0;
        check("single_valid", bus.res_valid, 1);
        check("single_sum",   bus.res_sum,   32'd12);
        check("single_carry", bus.res_carry, 0);
        check("single_ovf",   bus.res_ovf,   0);
        check("single_id",    bus.res_id,    0);

        // Arithmetic corners on requester 0.
        for (int c = 0; c < 3; c++) begin
            set_ops(0, corner_a[c], corner_b[c]);
            bus.req_valid = 4'b0001;
            cycle(0);
            bus.req_valid = '0;
            check("corner_sum",   bus.res_sum,   corner_s[c]);
            check("corner_carry", bus.res_carry, corner_c[c]);
            check("corner_ovf",   bus.res_ovf,   corner_v[c]);
        end

        // Round-robin: park the pointer at 0 via a grant to 3, then all request.
        for (int i = 0; i < N; i++) set_ops(i, 32'(100 * i), 32'(i));
        bus.req_valid = 4'b1000;
        cycle(3);
        bus.req_valid = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            cycle(rr_seq[s]);
            check("rr_res_id", bus.res_id, rr_seq[s]);
        end

        // Pointer wrap and skip.
        bus.req_valid = 4'b1000;
        cycle(3);
        bus.req_valid = 4'b0101;
        cycle(0);
        cycle(2);
        cycle(0);
        bus.req_valid = 4'b0100;
        cycle(2);
        cycle(2);
        cycle(2);

        // Backpressure: pending result, consumer stalled for 3 cycles.
        set_ops(1, 32'hDEAD_0000, 32'h0000_BEEF);
        bus.req_valid = 4'b0010;
        bus.res_ready = 1'b0;
        held_sum      = bus.res_sum;
        held_id       = bus.res_id;
        for (int s = 0; s < 3; s++) begin
            cycle(-1);
            check("stall_valid", bus.res_valid, 1);
            check("stall_sum",   bus.res_sum,   held_sum);
            check("stall_id",    bus.res_id,    held_id);
        end
        bus.res_ready = 1'b1;
        cycle(1);
        bus.req_valid = '0;
        check("bp_valid", bus.res_valid, 1);
        check("bp_sum",   bus.res_sum,   32'hDEAD_BEEF);
        check("bp_id",    bus.res_id,    1);
        cycle(-1);
        check("drain_valid", bus.res_valid, 0);
        check("drain_sum",   bus.res_sum,   32'hDEAD_BEEF);

        // Mid-operation reset with a pending result and pointer at 2.
        bus.req_valid = 4'b0010;
        cycle(1);
        bus.req_valid = '0;
        #2;
        reset_n = 1'b0;
        #1;
        check("mrst_valid",     bus.res_valid, 0);
        check("mrst_sum",       bus.res_sum,   0);
        check("mrst_id",        bus.res_id,    0);
        check("mrst_req_ready", bus.req_ready, 0);
        model_reset();
        @(negedge clk);
        reset_n       = 1'b1;
        bus.req_valid = 4'b1111;
        cycle(0);
        bus.req_valid = '0;
        cycle();

        // Randomized traffic with held operands, withdrawals and stalls.
        for (int i = 0; i < N; i++) pend[i] = 0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    if ($urandom_range(0, 7) == 0) pend[i] = 0;
                end else if ($urandom_range(0, 1) == 1) begin
                    pend[i] = 1;
                    op_a[i] = rnd_op();
                    op_b[i] = rnd_op();
                end
                set_ops(i, op_a[i], op_b[i]);
                bus.req_valid[i] = pend[i];
            end
            bus.res_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (last_w >= 0) pend[last_w] = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
